// File: rtl/maze_world_model.sv
// Grid-maze robot world: 8x8 wall map, timed moves/turns, wall detectors,
// collision pulses and a per-cell beacon map with a saturating count.
module maze_world_model #(
  parameter logic [63:0] MAP_E      = 64'h0,
  parameter logic [63:0] MAP_S      = 64'h0,
  parameter logic [2:0]  START_X    = 3'd0,
  parameter logic [2:0]  START_Y    = 3'd0,
  parameter logic [1:0]  START_DIR  = 2'd0,
  parameter logic [7:0]  STEP_TICKS = 8'd50,
  parameter logic [7:0]  TURN_TICKS = 8'd90
) (
  input  logic       clk_100hz,
  input  logic       reset,
  input  logic       move_forward,
  input  logic       move_backward,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       place_barrier_signal,
  input  logic       destroy_barrier_signal,
  output logic       front_detector,
  output logic       back_detector,
  output logic       left_detector,
  output logic       right_detector,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic [1:0] heading,
  output logic [3:0] beacon_count,
  output logic       collision
);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_BACK, S_TURN_L, S_TURN_R} state_t;

  // Walls of one cell, bit index = direction (0 N, 1 E, 2 S, 3 W)
  function automatic logic [3:0] cell_walls(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] w;
    w[0] = (y == 3'd0) || MAP_S[{y - 3'd1, x}];
    w[1] = (x == 3'd7) || MAP_E[{y, x}];
    w[2] = (y == 3'd7) || MAP_S[{y, x}];
    w[3] = (x == 3'd0) || MAP_E[{y, x - 3'd1}];
    return w;
  endfunction

  // Returns {front, back, left, right}
  function automatic logic [3:0] detect(input logic [2:0] x, input logic [2:0] y,
                                        input logic [1:0] h);
    logic [3:0] w;
    w = cell_walls(x, y);
    return {w[h], w[h + 2'd2], w[h + 2'd3], w[h + 2'd1]};
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_x, r_y;
  logic [1:0]  r_dir;
  logic [3:0]  r_det;
  logic [63:0] r_beacons;
  logic [3:0]  r_bcount;
  logic        r_collision, r_lock_fwd, r_lock_bwd;
  logic        r_place_d, r_destroy_d;

  logic       w_valid, w_fwd, w_bwd, w_tl, w_tr;
  logic [3:0] w_walls;
  logic       w_front, w_back, w_place, w_destroy;
  logic [1:0] w_mdir;
  logic [2:0] w_nx, w_ny;
  logic [5:0] w_cell;

  assign w_valid   = $onehot({move_forward, move_backward, turn_left, turn_right});
  assign w_fwd     = w_valid & move_forward;
  assign w_bwd     = w_valid & move_backward;
  assign w_tl      = w_valid & turn_left;
  assign w_tr      = w_valid & turn_right;
  assign w_walls   = cell_walls(r_x, r_y);
  assign w_front   = w_walls[r_dir];
  assign w_back    = w_walls[r_dir + 2'd2];
  assign w_place   = place_barrier_signal & ~r_place_d;
  assign w_destroy = destroy_barrier_signal & ~r_destroy_d;
  assign w_cell    = {r_y, r_x};
  assign w_mdir    = (r_state == S_BACK) ? r_dir + 2'd2 : r_dir;

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (w_mdir)
      2'd0: w_ny = r_y - 3'd1;
      2'd1: w_nx = r_x + 3'd1;
      2'd2: w_ny = r_y + 3'd1;
      default: w_nx = r_x - 3'd1;
    endcase
  end

  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= START_X;
      r_y         <= START_Y;
      r_dir       <= START_DIR;
      r_det       <= detect(START_X, START_Y, START_DIR);
      r_beacons   <= '0;
      r_bcount    <= '0;
      r_collision <= 1'b0;
      r_lock_fwd  <= 1'b0;
      r_lock_bwd  <= 1'b0;
      r_place_d   <= 1'b0;
      r_destroy_d <= 1'b0;
    end else begin
      r_det       <= detect(r_x, r_y, r_dir);
      r_collision <= 1'b0;
      r_lock_fwd  <= 1'b0;
      r_lock_bwd  <= 1'b0;
      r_place_d   <= place_barrier_signal;
      r_destroy_d <= destroy_barrier_signal;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // Lock stays set while a blocked command is held, so it pulses once
          if (w_fwd) begin
            if (w_front) begin
              r_collision <= ~r_lock_fwd;
              r_lock_fwd  <= 1'b1;
            end else begin
              r_state <= S_FWD;
            end
          end else if (w_bwd) begin
            if (w_back) begin
              r_collision <= ~r_lock_bwd;
              r_lock_bwd  <= 1'b1;
            end else begin
              r_state <= S_BACK;
            end
          end else if (w_tl) begin
            r_state <= S_TURN_L;
          end else if (w_tr) begin
            r_state <= S_TURN_R;
          end
        end
        S_FWD, S_BACK: begin
          if ((r_state == S_FWD) ? w_fwd : w_bwd) begin
            if (r_cnt == STEP_TICKS - 8'd1) begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_TURN_L, S_TURN_R: begin
          if ((r_state == S_TURN_L) ? w_tl : w_tr) begin
            if (r_cnt == TURN_TICKS - 8'd1) begin
              r_dir   <= (r_state == S_TURN_L) ? r_dir - 2'd1 : r_dir + 2'd1;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      if (w_place && !w_destroy && !r_beacons[w_cell]) begin
        r_beacons[w_cell] <= 1'b1;
        if (r_bcount != 4'd15) r_bcount <= r_bcount + 4'd1;
      end else if (w_destroy && !w_place && r_beacons[w_cell]) begin
        r_beacons[w_cell] <= 1'b0;
        if (r_bcount != 4'd0) r_bcount <= r_bcount - 4'd1;
      end
    end
  end

  assign {front_detector, back_detector, left_detector, right_detector} = r_det;
  assign pos_x        = r_x;
  assign pos_y        = r_y;
  assign heading      = r_dir;
  assign beacon_count = r_bcount;
  assign collision    = r_collision;

endmodule

// File: tb/tb_maze_world_model.sv
// Directed table-driven bench for maze_world_model with a small wall map:
// east wall and south wall on cell (2,0).
module tb_maze_world_model;

  logic       clk_100hz = 1'b0;
  logic       reset;
  logic       move_forward, move_backward, turn_left, turn_right;
  logic       place_barrier_signal, destroy_barrier_signal;
  logic       front_detector, back_detector, left_detector, right_detector;
  logic [2:0] pos_x, pos_y;
  logic [1:0] heading;
  logic [3:0] beacon_count;
  logic       collision;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk_100hz = ~clk_100hz;

  maze_world_model #(
    .MAP_E(64'h4),
    .MAP_S(64'h4)
  ) dut (
    .clk_100hz(clk_100hz),
    .reset(reset),
    .move_forward(move_forward),
    .move_backward(move_backward),
    .turn_left(turn_left),
    .turn_right(turn_right),
    .place_barrier_signal(place_barrier_signal),
    .destroy_barrier_signal(destroy_barrier_signal),
    .front_detector(front_detector),
    .back_detector(back_detector),
    .left_detector(left_detector),
    .right_detector(right_detector),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .heading(heading),
    .beacon_count(beacon_count),
    .collision(collision)
  );

  // in = {fwd, bwd, tl, tr, place, destroy}; det = {front, back, left, right}
  typedef struct {
    string       name;
    logic [5:0]  in;
    int unsigned n;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [1:0]  h;
    logic [3:0]  bc;
    logic [3:0]  det;
    int unsigned colls;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic [5:0] in);
    {move_forward, move_backward, turn_left, turn_right,
     place_barrier_signal, destroy_barrier_signal} = in;
  endtask

  // Hold inputs for n edges, then idle 2 edges; counts collision pulses.
  task automatic apply(input logic [5:0] in, input int unsigned n, output int unsigned colls);
    colls = 0;
    drive(in);
    repeat (n) begin
      @(posedge clk_100hz);
      @(negedge clk_100hz);
      if (collision) colls++;
    end
    drive(6'b0);
    repeat (2) begin
      @(posedge clk_100hz);
      @(negedge clk_100hz);
      if (collision) colls++;
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] x, input logic [2:0] y,
                             input logic [1:0] h, input logic [3:0] bc,
                             input logic [3:0] det);
    chk({tag, ".pos_x"}, pos_x, x);
    chk({tag, ".pos_y"}, pos_y, y);
    chk({tag, ".heading"}, heading, h);
    chk({tag, ".beacon_count"}, beacon_count, bc);
    chk({tag, ".detectors"},
        {front_detector, back_detector, left_detector, right_detector}, det);
  endtask

  initial begin
    int unsigned colls;

    vecs[0]  = '{"blocked_north",   6'b100000, 200, 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010, 1};
    vecs[1]  = '{"reblock_north",   6'b100000,   5, 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010, 1};
    vecs[2]  = '{"turn_r_abort",    6'b000100,  45, 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010, 0};
    vecs[3]  = '{"turn_r_full",     6'b000100,  91, 3'd0, 3'd0, 2'd1, 4'd0, 4'b0110, 0};
    vecs[4]  = '{"fwd_two_cells",   6'b100000, 102, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 0};
    vecs[5]  = '{"blocked_map_e",   6'b100000,  10, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 1};
    vecs[6]  = '{"fwd_and_tl",      6'b101000,  30, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 0};
    vecs[7]  = '{"back_abort",      6'b010000,  30, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 0};
    vecs[8]  = '{"place",           6'b000010,   1, 3'd2, 3'd0, 2'd1, 4'd1, 4'b1011, 0};
    vecs[9]  = '{"place_again",     6'b000010,   1, 3'd2, 3'd0, 2'd1, 4'd1, 4'b1011, 0};
    vecs[10] = '{"place_destroy",   6'b000011,   1, 3'd2, 3'd0, 2'd1, 4'd1, 4'b1011, 0};
    vecs[11] = '{"destroy",         6'b000001,   1, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 0};
    vecs[12] = '{"destroy_again",   6'b000001,   1, 3'd2, 3'd0, 2'd1, 4'd0, 4'b1011, 0};
    vecs[13] = '{"back_one_cell",   6'b010000,  51, 3'd1, 3'd0, 2'd1, 4'd0, 4'b0010, 0};
    vecs[14] = '{"place_cell_1_0",  6'b000010,   1, 3'd1, 3'd0, 2'd1, 4'd1, 4'b0010, 0};
    vecs[15] = '{"turn_l_full",     6'b001000,  91, 3'd1, 3'd0, 2'd0, 4'd1, 4'b1000, 0};
    vecs[16] = '{"back_south",      6'b010000,  51, 3'd1, 3'd1, 2'd0, 4'd1, 4'b0000, 0};

    reset = 1'b1;
    drive(6'b0);
    repeat (3) @(posedge clk_100hz);
    @(negedge clk_100hz);
    reset = 1'b0;
    check_state("reset", 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010);
    chk("reset.collision", collision, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].in, vecs[i].n, colls);
      check_state(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].h, vecs[i].bc, vecs[i].det);
      chk({vecs[i].name, ".collisions"}, colls, vecs[i].colls);
    end

    // Reset in the middle of a forward move from (1,1) facing north
    drive(6'b100000);
    repeat (30) @(posedge clk_100hz);
    @(negedge clk_100hz);
    reset = 1'b1;
    @(posedge clk_100hz);
    @(negedge clk_100hz);
    reset = 1'b0;
    drive(6'b0);
    check_state("reset_mid_move", 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010);
    chk("reset_mid_move.collision", collision, 0);
    apply(6'b0, 60, colls);
    check_state("idle_after_reset", 3'd0, 3'd0, 2'd0, 4'd0, 4'b1010);
    chk("idle_after_reset.collisions", colls, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
